// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and sizing helpers for the load-use hazard scoreboard.
package hazard_pkg;

    localparam int DEF_REG_NUM_BITWIDTH = 5;

    typedef logic [DEF_REG_NUM_BITWIDTH-1:0] reg_idx_t;

    // Width needed to hold every count from 0 up to max_count inclusive.
    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side signal bundle for the hazard scoreboard: the pipeline is master, the unit is slave.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
    parameter int MAX_OUTSTANDING  = 4
);
    localparam int CNT_W = count_width(MAX_OUTSTANDING);

    logic                        id_valid;
    logic                        id_memRead;
    logic [REG_NUM_BITWIDTH-1:0] id_Rd;
    logic [REG_NUM_BITWIDTH-1:0] if_Rs1;
    logic [REG_NUM_BITWIDTH-1:0] if_Rs2;
    logic                        if_useRs1;
    logic                        if_useRs2;
    logic                        if_memRead;
    logic [REG_NUM_BITWIDTH-1:0] if_Rd;
    logic                        mem_resp_valid;
    logic [REG_NUM_BITWIDTH-1:0] mem_resp_Rd;
    logic                        flush;
    logic                        if_doNOP;
    logic                        if_write;
    logic                        PCWrite;
    logic [CNT_W-1:0]            outstanding;

    modport master (
        output id_valid, id_memRead, id_Rd,
        output if_Rs1, if_Rs2, if_useRs1, if_useRs2, if_memRead, if_Rd,
        output mem_resp_valid, mem_resp_Rd, flush,
        input  if_doNOP, if_write, PCWrite, outstanding
    );

    modport slave (
        input  id_valid, id_memRead, id_Rd,
        input  if_Rs1, if_Rs2, if_useRs1, if_useRs2, if_memRead, if_Rd,
        input  mem_resp_valid, mem_resp_Rd, flush,
        output if_doNOP, if_write, PCWrite, outstanding
    );

endinterface

// File: rtl/hazard_scoreboard_pending_scoreboard.sv
// Per-register "load result pending" flags with one set port, one clear port and NUM_RD read ports.
module pending_scoreboard #(
    parameter int IDX_W  = 5,
    parameter int NUM_RD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx  [NUM_RD],
    output logic             rd_pend [NUM_RD]
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [DEPTH-1:0] pending;

    // NOTE: this is a flag vector, not storage RAM; every bit must start clear,
    // so the whole vector is reset rather than left uninitialised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr_en) begin
                pending[clr_idx] <= 1'b0;
            end
            // NOTE: both writes are non-blocking, so the later set overrides an
            // earlier clear of the same bit within one edge: set wins.
            if (set_en && (set_idx != '0)) begin
                pending[set_idx] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_pend[i] = pending[rd_idx[i]];
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit for a variable-latency data memory: stalls IF/PC on RAW, load WAW and load capacity.
// Optional HAZARD_PERF_EN adds a saturating stall_cycles counter port.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
    parameter int WORD_BITWIDTH    = 32,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef HAZARD_PERF_EN
    output logic [WORD_BITWIDTH-1:0] stall_cycles,
`endif
    hazard_scoreboard_if.slave       bus
);
    localparam int CNT_W = count_width(MAX_OUTSTANDING);

    if ((MAX_OUTSTANDING < 1) || (WORD_BITWIDTH < 1)) begin : g_bad_param
        $error("hazard_scoreboard: MAX_OUTSTANDING and WORD_BITWIDTH must be >= 1");
    end

    logic [REG_NUM_BITWIDTH-1:0] rd_idx  [4];
    logic                        rd_pend [4];
    logic [CNT_W-1:0]            cnt;
    logic                        issue;
    logic                        resp;
    logic                        raw_rs1;
    logic                        raw_rs2;
    logic                        waw;
    logic                        full;
    logic                        stall;

    assign rd_idx[0] = bus.mem_resp_Rd;
    assign rd_idx[1] = bus.if_Rs1;
    assign rd_idx[2] = bus.if_Rs2;
    assign rd_idx[3] = bus.if_Rd;

    assign issue = bus.id_valid & bus.id_memRead & (bus.id_Rd != '0) & ~bus.flush;
    assign resp  = bus.mem_resp_valid & rd_pend[0];

    pending_scoreboard #(
        .IDX_W  (REG_NUM_BITWIDTH),
        .NUM_RD (4)
    ) u_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue),
        .set_idx (bus.id_Rd),
        .clr_en  (resp),
        .clr_idx (bus.mem_resp_Rd),
        .rd_idx  (rd_idx),
        .rd_pend (rd_pend)
    );

    // Hazards see the pending vector as registered; a response only lifts them next cycle.
    assign raw_rs1 = bus.if_useRs1 & (bus.if_Rs1 != '0)
                   & (rd_pend[1] | (issue & (bus.id_Rd == bus.if_Rs1)));
    assign raw_rs2 = bus.if_useRs2 & (bus.if_Rs2 != '0)
                   & (rd_pend[2] | (issue & (bus.id_Rd == bus.if_Rs2)));
    assign waw     = bus.if_memRead & (bus.if_Rd != '0)
                   & (rd_pend[3] | (issue & (bus.id_Rd == bus.if_Rd)));

    // cnt + issue - resp >= MAX, rearranged so no intermediate value goes negative.
    assign full = bus.if_memRead
                & (({1'b0, cnt} + (CNT_W+1)'(issue))
                   >= ((CNT_W+1)'(MAX_OUTSTANDING) + (CNT_W+1)'(resp)));

    assign stall = (raw_rs1 | raw_rs2 | waw | full) & ~bus.flush & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({issue, resp})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.if_doNOP    = stall;
    assign bus.if_write    = ~stall;
    assign bus.PCWrite     = ~stall;
    assign bus.outstanding = rst_n ? cnt : '0;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Next-generation load-use hazard unit for the 5-stage RISC-V pipeline, supporting a variable-latency, pipelined data memory. A per-register pending scoreboard marks destination registers of loads issued from ID and clears them on memory response, so load latency is not fixed. It stalls IF/PC on:
- RAW against pending or same-cycle-issuing loads;
- WAW between loads;
- outstanding-load capacity exhaustion.

It honours branch flush and sits beside the IF/ID register and PC logic.

Parameters:
REG_NUM_BITWIDTH, 5, register index width; scoreboard depth is 2**REG_NUM_BITWIDTH.
WORD_BITWIDTH, 32, datapath width; only the perf counter uses it.
MAX_OUTSTANDING, 4, maximum loads in flight (>=1).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
id_valid  input  1  ID holds a real instruction.
id_memRead  input  1  ID instruction is a load.
id_Rd  input  REG_NUM_BITWIDTH  ID destination register.
if_Rs1  input  REG_NUM_BITWIDTH  IF source register 1.
if_Rs2  input  REG_NUM_BITWIDTH  IF source register 2.
if_useRs1  input  1  IF instruction reads Rs1.
if_useRs2  input  1  IF instruction reads Rs2.
if_memRead  input  1  IF instruction is a load.
if_Rd  input  REG_NUM_BITWIDTH  IF destination register.
mem_resp_valid  input  1  load data returned this cycle.
mem_resp_Rd  input  REG_NUM_BITWIDTH  register written by the returning load.
flush  input  1  branch taken; IF and ID instructions squashed.
if_doNOP  output  1  insert bubble into ID.
if_write  output  1  IF/ID register write enable.
PCWrite  output  1  PC write enable.
outstanding  output  $clog2(MAX_OUTSTANDING+1)  loads in flight.

Behaviour:
- State:
  - pending[2**REG_NUM_BITWIDTH-1:0];
  - outstanding counter.
  - Both cleared when rst_n=0 at a clk edge.
  - pending[0] is never set.
- issue = id_valid & id_memRead & (id_Rd!=0) & !flush.
- resp = mem_resp_valid & pending[mem_resp_Rd].
  - A response to a non-pending register is ignored and has no count change.
- Next pending:
  - the bit for mem_resp_Rd is cleared when resp;
  - the bit for id_Rd is set when issue;
  - set wins when both target the same register in one cycle.
- Outstanding count:
  - +1 on issue alone;
  - -1 on resp alone;
  - unchanged when both occur or neither occurs.
  - It never exceeds MAX_OUTSTANDING; the stall logic guarantees this.
- Hazard terms (all combinational, same cycle):
  - raw = (if_useRs1 & if_Rs1!=0 & (pending[if_Rs1] | (issue & id_Rd==if_Rs1))) | the same term for Rs2.
  - waw = if_memRead & if_Rd!=0 & (pending[if_Rd] | (issue & id_Rd==if_Rd)).
  - full = if_memRead & (outstanding + issue - resp >= MAX_OUTSTANDING).
- stall = (raw | waw | full) & !flush & rst_n.
- Outputs:
  - if_doNOP = stall;
  - if_write = !stall;
  - PCWrite = !stall.
  - Stall holds for as many cycles as the condition persists; there is no fixed latency.
- A same-cycle response counts as resolving the hazard in the next cycle only. There is no bypass of pending into the current-cycle stall.
  - Exception: the full term subtracts a same-cycle resp.
- Flush:
  - suppresses issue and forces stall=0;
  - does not clear pending bits of loads already past ID.
- During reset (rst_n=0): if_doNOP=0, if_write=1, PCWrite=1, outstanding=0.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds output stall_cycles [WORD_BITWIDTH-1:0].
  - Increments each cycle stall=1.
  - Saturates at all-ones.
  - Cleared on reset.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - REG_NUM_BITWIDTH default;
  - reg_idx_t typedef;
  - a count-width helper function.
- Sub-module pending_scoreboard holds the pending vector with set/clear/read ports. It is instantiated once; the counter and hazard logic stay in the top.

Test Plan:
1. Reset, then load x5 issues in ID; IF reads if_Rs1=5 -> if_doNOP=1, PCWrite=0 that cycle. Stall persists until mem_resp_Rd=5, then releases one cycle later.
2. Loads to x1, x2, x3, x4 issue on consecutive cycles with no responses. A fifth load in IF -> full stall with outstanding=4. One response -> next cycle the load proceeds.
3. Load x7 issued, and the same cycle a response for x7 arrives with x7 pending -> x7 stays pending and outstanding is unchanged.
4. IF load with if_Rd=9 while x9 is pending -> WAW stall. A non-load reading only x10 -> no stall.
5. flush=1 while ID holds load x6 and IF reads x6 -> no stall and x6 not set. Other pending bits are retained.
6. if_Rs1=0 with id_Rd=0 load -> never stalls. Response to non-pending x12 -> outstanding unchanged. With HAZARD_PERF_EN, stall_cycles equals the count of stalled cycles.
